// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master round-robin arbiter in front of a single-port 1-cycle-latency RAM
// Define ONCHIP_ARB_STATS_EN to add the stat_grants_a/stat_grants_b/stat_conflicts counters.
module onchip_mem_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   ma_address,
    input  logic [DATA_W/8-1:0] ma_byteenable,
    input  logic                ma_read,
    input  logic                ma_write,
    input  logic [DATA_W-1:0]   ma_writedata,
    output logic                ma_waitrequest,
    output logic [DATA_W-1:0]   ma_readdata,
    output logic                ma_readdatavalid,
    input  logic [ADDR_W-1:0]   mb_address,
    input  logic [DATA_W/8-1:0] mb_byteenable,
    input  logic                mb_read,
    input  logic                mb_write,
    input  logic [DATA_W-1:0]   mb_writedata,
    output logic                mb_waitrequest,
    output logic [DATA_W-1:0]   mb_readdata,
    output logic                mb_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
`ifdef ONCHIP_ARB_STATS_EN
    ,
    output logic [31:0]         stat_grants_a,
    output logic [31:0]         stat_grants_b,
    output logic [31:0]         stat_conflicts
`endif
);
    typedef enum logic {OWN_A, OWN_B} owner_t;
    owner_t     owner;
    logic [3:0] burst_cnt;
    logic       rd_pend, rd_owner_b;
    logic       req_a, req_b, keep, gnt_a, gnt_b, rd_issue;
    always_comb begin
        req_a    = ma_read | ma_write;
        req_b    = mb_read | mb_write;
        keep     = burst_cnt < 4'(MAX_BURST);
        // Under contention the owner keeps the RAM only while its burst budget lasts
        gnt_a    = !reset && req_a && (!req_b || ((owner == OWN_A) == keep));
        gnt_b    = !reset && req_b && !gnt_a;
        rd_issue = gnt_a ? (ma_read && !ma_write) : (gnt_b && mb_read && !mb_write);
    end
    assign ma_waitrequest   = !gnt_a;
    assign mb_waitrequest   = !gnt_b;
    assign mem_address      = gnt_b ? mb_address : ma_address;
    assign mem_byteenable   = gnt_b ? mb_byteenable : ma_byteenable;
    assign mem_writedata    = gnt_b ? mb_writedata : ma_writedata;
    assign mem_chipselect   = gnt_a | gnt_b;
    assign mem_write        = gnt_a ? ma_write : (gnt_b && mb_write);
    assign mem_clken        = !reset;
    assign ma_readdata      = mem_readdata;
    assign mb_readdata      = mem_readdata;
    // Gating with reset drops the response to a read accepted just before reset
    assign ma_readdatavalid = rd_pend && !rd_owner_b && !reset;
    assign mb_readdatavalid = rd_pend && rd_owner_b && !reset;
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_A;
            burst_cnt  <= '0;
            rd_pend    <= 1'b0;
            rd_owner_b <= 1'b0;
        end else begin
            rd_pend    <= rd_issue;
            rd_owner_b <= gnt_b;
            if (!(gnt_a || gnt_b))
                burst_cnt <= '0;
            else if (gnt_b == (owner == OWN_B))
                burst_cnt <= (burst_cnt == 4'(MAX_BURST)) ? burst_cnt : burst_cnt + 4'd1;
            else begin
                owner     <= gnt_b ? OWN_B : OWN_A;
                burst_cnt <= 4'd1;
            end
        end
    end
`ifdef ONCHIP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants_a  <= '0;
            stat_grants_b  <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_grants_a  <= stat_grants_a + 32'(gnt_a);
            stat_grants_b  <= stat_grants_b + 32'(gnt_b);
            stat_conflicts <= stat_conflicts + 32'(req_a && req_b);
        end
    end
`endif
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed and randomized checks of onchip_mem_arbiter against a RAM and reference model
module tb_onchip_mem_arbiter;
    localparam int MB = 4;
    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ma_address, mb_address, mem_address;
    logic [3:0]  ma_byteenable, mb_byteenable, mem_byteenable;
    logic        ma_read, ma_write, mb_read, mb_write;
    logic [31:0] ma_writedata, mb_writedata, ma_readdata, mb_readdata, mem_writedata, mem_readdata;
    logic        ma_waitrequest, mb_waitrequest, ma_readdatavalid, mb_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_ARB_STATS_EN
    logic [31:0] stat_grants_a, stat_grants_b, stat_conflicts;
`endif
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] ram [0:32767];
    logic [31:0] ram_q;
    logic [31:0] ref_mem [0:15];

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(15), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .ma_address(ma_address), .ma_byteenable(ma_byteenable), .ma_read(ma_read), .ma_write(ma_write),
        .ma_writedata(ma_writedata), .ma_waitrequest(ma_waitrequest), .ma_readdata(ma_readdata),
        .ma_readdatavalid(ma_readdatavalid),
        .mb_address(mb_address), .mb_byteenable(mb_byteenable), .mb_read(mb_read), .mb_write(mb_write),
        .mb_writedata(mb_writedata), .mb_waitrequest(mb_waitrequest), .mb_readdata(mb_readdata),
        .mb_readdatavalid(mb_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
`ifdef ONCHIP_ARB_STATS_EN
        , .stat_grants_a(stat_grants_a), .stat_grants_b(stat_grants_b), .stat_conflicts(stat_conflicts)
`endif
    );

    // Single-port RAM with byte lanes and one-cycle read latency
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        ma_read = 0; ma_write = 0; mb_read = 0; mb_write = 0;
        ma_address = '0; mb_address = '0; ma_byteenable = 4'hF; mb_byteenable = 4'hF;
        ma_writedata = '0; mb_writedata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; ma_read = 1; ma_address = 15'h0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (ma_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait: got %b want 1", ma_waitrequest); end
            if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
            if ({ma_readdatavalid, mb_readdatavalid} !== 2'b00) begin
                n_fail++; $display("FAIL reset_valid: got %b want 00", {ma_readdatavalid, mb_readdatavalid});
            end
            @(posedge clk) #1;
        end
        reset = 0;
        @(negedge clk);
        n_checks += 3;
        if (ma_waitrequest !== 1'b0) begin n_fail++; $display("FAIL post_reset_grant: got %b want 0", ma_waitrequest); end
        if (mem_chipselect !== 1'b1) begin n_fail++; $display("FAIL post_reset_cs: got %b want 1", mem_chipselect); end
        if (mem_address !== 15'h0055) begin n_fail++; $display("FAIL post_reset_addr: got %h want 0055", mem_address); end
        @(posedge clk) #1;
        idle_inputs();
        @(posedge clk) #1;
    endtask

    task automatic test_write_read();
        idle_inputs();
        ma_write = 1; ma_address = 15'h0010; ma_writedata = 32'hDEADBEEF; ma_byteenable = 4'hF;
        @(negedge clk);
        n_checks += 2;
        if (ma_waitrequest !== 1'b0) begin n_fail++; $display("FAIL wr_grant: got %b want 0", ma_waitrequest); end
        if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wr_memwrite: got %b want 1", mem_write); end
        @(posedge clk) #1;
        ma_write = 0; ma_read = 1;
        @(negedge clk);
        n_checks += 2;
        if (ma_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rd_grant: got %b want 0", ma_waitrequest); end
        if (ma_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %b want 0", ma_readdatavalid); end
        @(posedge clk) #1;
        ma_read = 0;
        @(negedge clk);
        n_checks += 3;
        if (ma_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", ma_readdatavalid); end
        if (ma_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", ma_readdata); end
        if (mb_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_b_valid: got %b want 0", mb_readdatavalid); end
        @(posedge clk) #1;
        @(negedge clk);
        n_checks++;
        if (ma_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_once: got %b want 0", ma_readdatavalid); end
        @(posedge clk) #1;
    endtask

    task automatic test_byteenable();
        idle_inputs();
        ma_write = 1; ma_address = 15'h0020; ma_writedata = 32'hDEADBEEF; ma_byteenable = 4'hF;
        @(posedge clk) #1;
        ma_writedata = 32'h12345678; ma_byteenable = 4'h3;
        @(posedge clk) #1;
        ma_write = 0; ma_read = 1;
        @(posedge clk) #1;
        ma_read = 0;
        @(negedge clk);
        n_checks += 2;
        if (ma_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL be_valid: got %b want 1", ma_readdatavalid); end
        if (ma_readdata !== 32'hDEAD5678) begin n_fail++; $display("FAIL be_data: got %h want dead5678", ma_readdata); end
        @(posedge clk) #1;
    endtask

    task automatic test_burst();
        int wa, wb, max_wa, max_wb;
        bit exp_a;
        do_reset();
        wa = 0; wb = 0; max_wa = 0; max_wb = 0;
        ma_read = 1; ma_address = 15'h0001; mb_read = 1; mb_address = 15'h0002;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp_a = ((i / MB) % 2) == 0;
            n_checks += 2;
            if (ma_waitrequest !== !exp_a) begin n_fail++; $display("FAIL burst_a[%0d]: got wait %b want %b", i, ma_waitrequest, !exp_a); end
            if (mb_waitrequest !== exp_a) begin n_fail++; $display("FAIL burst_b[%0d]: got wait %b want %b", i, mb_waitrequest, exp_a); end
            wa = ma_waitrequest ? wa + 1 : 0;
            wb = mb_waitrequest ? wb + 1 : 0;
            if (wa > max_wa) max_wa = wa;
            if (wb > max_wb) max_wb = wb;
            @(posedge clk) #1;
        end
        n_checks += 2;
        if (max_wa > MB) begin n_fail++; $display("FAIL burst_wait_a: got %0d want <= %0d", max_wa, MB); end
        if (max_wb > MB) begin n_fail++; $display("FAIL burst_wait_b: got %0d want <= %0d", max_wb, MB); end
        idle_inputs();
        @(posedge clk) #1;
    endtask

    task automatic test_b_stream();
        idle_inputs();
        mb_write = 1; mb_address = 15'h7FFF; mb_writedata = 32'hCAFE0001;
        @(posedge clk) #1;
        mb_write = 0; mb_read = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (mb_waitrequest !== 1'b0) begin n_fail++; $display("FAIL bstream_grant[%0d]: got %b want 0", i, mb_waitrequest); end
            if (mb_readdatavalid !== (i > 0)) begin n_fail++; $display("FAIL bstream_valid[%0d]: got %b want %b", i, mb_readdatavalid, i > 0); end
            if (i > 0) begin
                n_checks++;
                if (mb_readdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL bstream_data[%0d]: got %h want cafe0001", i, mb_readdata); end
            end
            @(posedge clk) #1;
        end
        mb_read = 0;
        @(negedge clk);
        n_checks += 2;
        if (mb_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL bstream_last: got %b want 1", mb_readdatavalid); end
        if (ma_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL bstream_a_valid: got %b want 0", ma_readdatavalid); end
        @(posedge clk) #1;
    endtask

    task automatic test_random();
        bit   own_b, pend, pend_b, ra, rb;
        int   run, g;
        logic [31:0] pend_data;
        logic [31:0] e_ga, e_gb, e_cf;
        int   r;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ma_write = 1; ma_address = 15'h0100 + 15'(i); ma_byteenable = 4'hF; ma_writedata = $urandom;
            ref_mem[i] = ma_writedata;
            @(posedge clk) #1;
        end
        idle_inputs();
        @(posedge clk) #1;
        own_b = 0; run = 0; pend = 0; pend_b = 0; pend_data = '0;
        e_ga = 32'd16; e_gb = 0; e_cf = 0;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            ma_read = (r >= 3 && r < 6) || r == 9; ma_write = r >= 6;
            r = $urandom_range(0, 9);
            mb_read = (r >= 3 && r < 6) || r == 9; mb_write = r >= 6;
            ma_address = 15'h0100 + 15'($urandom_range(0, 15)); mb_address = 15'h0100 + 15'($urandom_range(0, 15));
            ma_byteenable = 4'($urandom); mb_byteenable = 4'($urandom);
            ma_writedata = $urandom; mb_writedata = $urandom;
            ra = ma_read | ma_write; rb = mb_read | mb_write;
            if (ra && rb) g = (run < MB) ? (own_b ? 2 : 1) : (own_b ? 1 : 2);
            else g = ra ? 1 : (rb ? 2 : 0);
            @(negedge clk);
            n_checks += 5;
            if (ma_waitrequest !== (g != 1)) begin n_fail++; $display("FAIL rnd_wait_a[%0d]: got %b want %b", c, ma_waitrequest, g != 1); end
            if (mb_waitrequest !== (g != 2)) begin n_fail++; $display("FAIL rnd_wait_b[%0d]: got %b want %b", c, mb_waitrequest, g != 2); end
            if (mem_chipselect !== (g != 0)) begin n_fail++; $display("FAIL rnd_cs[%0d]: got %b want %b", c, mem_chipselect, g != 0); end
            if (ma_readdatavalid !== (pend && !pend_b)) begin n_fail++; $display("FAIL rnd_valid_a[%0d]: got %b want %b", c, ma_readdatavalid, pend && !pend_b); end
            if (mb_readdatavalid !== (pend && pend_b)) begin n_fail++; $display("FAIL rnd_valid_b[%0d]: got %b want %b", c, mb_readdatavalid, pend && pend_b); end
            if (pend) begin
                n_checks++;
                if ((pend_b ? mb_readdata : ma_readdata) !== pend_data) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, pend_b ? mb_readdata : ma_readdata, pend_data);
                end
            end
            if (g != 0) begin
                n_checks += 2;
                if (mem_address !== (g == 2 ? mb_address : ma_address)) begin
                    n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, mem_address, g == 2 ? mb_address : ma_address);
                end
                if (mem_write !== (g == 2 ? mb_write : ma_write)) begin
                    n_fail++; $display("FAIL rnd_memwrite[%0d]: got %b want %b", c, mem_write, g == 2 ? mb_write : ma_write);
                end
            end
            pend = 0;
            if (g == 1) begin
                e_ga++;
                if (ma_write) ref_mem[ma_address[3:0]] = merge(ref_mem[ma_address[3:0]], ma_writedata, ma_byteenable);
                else begin pend = 1; pend_b = 0; pend_data = ref_mem[ma_address[3:0]]; end
            end else if (g == 2) begin
                e_gb++;
                if (mb_write) ref_mem[mb_address[3:0]] = merge(ref_mem[mb_address[3:0]], mb_writedata, mb_byteenable);
                else begin pend = 1; pend_b = 1; pend_data = ref_mem[mb_address[3:0]]; end
            end
            if (ra && rb) e_cf++;
            if (g == 0) run = 0;
            else if ((g == 2) == own_b) run = (run < MB) ? run + 1 : MB;
            else begin own_b = (g == 2); run = 1; end
            @(posedge clk) #1;
        end
        idle_inputs();
`ifdef ONCHIP_ARB_STATS_EN
        n_checks += 3;
        if (stat_grants_a !== e_ga) begin n_fail++; $display("FAIL stat_grants_a: got %0d want %0d", stat_grants_a, e_ga); end
        if (stat_grants_b !== e_gb) begin n_fail++; $display("FAIL stat_grants_b: got %0d want %0d", stat_grants_b, e_gb); end
        if (stat_conflicts !== e_cf) begin n_fail++; $display("FAIL stat_conflicts: got %0d want %0d", stat_conflicts, e_cf); end
`endif
        @(posedge clk) #1;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ma_read = 1; ma_address = 15'h0010;
        @(negedge clk);
        n_checks++;
        if (ma_waitrequest !== 1'b0) begin n_fail++; $display("FAIL mid_grant: got %b want 0", ma_waitrequest); end
        @(posedge clk) #1;
        ma_read = 0; reset = 1;
        @(negedge clk);
        n_checks += 2;
        if (ma_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", ma_readdatavalid); end
        if (mem_clken !== 1'b0) begin n_fail++; $display("FAIL mid_clken: got %b want 0", mem_clken); end
        @(posedge clk) #1;
        reset = 0;
        @(negedge clk);
        n_checks += 2;
        if (ma_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_after: got %b want 0", ma_readdatavalid); end
        if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL mid_clken_after: got %b want 1", mem_clken); end
`ifdef ONCHIP_ARB_STATS_EN
        n_checks++;
        if ({stat_grants_a, stat_grants_b, stat_conflicts} !== 96'd0) begin
            n_fail++; $display("FAIL mid_stats: got %0d/%0d/%0d want 0/0/0", stat_grants_a, stat_grants_b, stat_conflicts);
        end
`endif
        @(posedge clk) #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_burst();
        test_b_stream();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
